// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding, stage-control bundle and timeout default.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_POST_FLUSH = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MEM_TIMEOUT_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic ex_mem_flush;
    logic mem_wb_write;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
    id_ex_write: 1'b1, id_ex_bubble: 1'b0, ex_mem_write: 1'b1,
    ex_mem_flush: 1'b0, mem_wb_write: 1'b1};

  localparam stage_ctrl_t CTRL_RST = '{
    pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
    id_ex_write: 1'b0, id_ex_bubble: 1'b1, ex_mem_write: 1'b0,
    ex_mem_flush: 1'b1, mem_wb_write: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from ID/EX/MEM and stage-register controls.
// master: hazard controller side; slave: pipeline datapath side.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_memread;
  logic       mem_branch_taken;
  logic       dmem_req;
  logic       dmem_ready;

  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_write;
  logic id_ex_bubble;
  logic ex_mem_write;
  logic ex_mem_flush;
  logic mem_wb_write;

  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rd, ex_memread, mem_branch_taken,
    input  dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush,
    output id_ex_write, id_ex_bubble,
    output ex_mem_write, ex_mem_flush, mem_wb_write
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rd, ex_memread, mem_branch_taken,
    output dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush,
    input  id_ex_write, id_ex_bubble,
    input  ex_mem_write, ex_mem_flush, mem_wb_write
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect_unit.sv
// Load-use comparator: ID source register against an EX load's rd.
// x0 is never a hazard since it is hardwired to zero.
module hazard_detect_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       load_use
);
  logic hit1;
  logic hit2;

  assign hit1 = id_uses_rs1 && (id_rs1 == ex_rd);
  assign hit2 = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_memread && (ex_rd != REG_ZERO)
                    && (hit1 || hit2);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline.
// Mealy stage controls, memory-wait FSM, bring-up counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             res,
  pipeline_hazard_ctrl_if.master hz,
  output logic [1:0]       state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [3:0] TO_LAST = 4'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt, wait_d;
  logic        err_d;
  logic        stall_inc, flush_inc;
  logic        mem_stall, lu_en, load_use;
  stage_ctrl_t ctl;

  hazard_detect_unit u_hdu (
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .id_uses_rs1 (hz.id_uses_rs1),
    .id_uses_rs2 (hz.id_uses_rs2),
    .ex_rd       (hz.ex_rd),
    .ex_memread  (hz.ex_memread),
    .load_use    (load_use)
  );

  always_comb begin
    state_d   = ST_RUN;
    wait_d    = '0;
    err_d     = timeout_err;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    mem_stall = 1'b0;
    lu_en     = 1'b1;
    ctl       = CTRL_RUN;

    unique case (state_q)
      ST_MEM_WAIT: begin
        if (!hz.dmem_ready) begin
          if (wait_cnt == TO_LAST) begin
            err_d = 1'b1;
          end else begin
            mem_stall = 1'b1;
            state_d   = ST_MEM_WAIT;
            wait_d    = wait_cnt + 4'd1;
          end
        end
      end
      ST_POST_FLUSH: begin
        lu_en = 1'b0;
        if (hz.dmem_req && !hz.dmem_ready) begin
          mem_stall = 1'b1;
          state_d   = ST_MEM_WAIT;
          wait_d    = 4'd1;
        end
      end
      default: begin
        if (hz.dmem_req && !hz.dmem_ready) begin
          mem_stall = 1'b1;
          state_d   = ST_MEM_WAIT;
          wait_d    = 4'd1;
        end
      end
    endcase

    // ready/timeout exits fall through to the normal RUN priorities
    if (mem_stall) begin
      ctl = '0;
    end else if (hz.mem_branch_taken) begin
      ctl.if_id_flush  = 1'b1;
      ctl.id_ex_bubble = 1'b1;
      ctl.ex_mem_flush = 1'b1;
      flush_inc = 1'b1;
      state_d   = ST_POST_FLUSH;
    end else if (lu_en && load_use) begin
      ctl.pc_write     = 1'b0;
      ctl.if_id_write  = 1'b0;
      ctl.id_ex_bubble = 1'b1;
      stall_inc = 1'b1;
    end

    if (res) ctl = CTRL_RST;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt    <= wait_d;
      timeout_err <= err_d;
      if (stall_inc && stall_count != CNT_MAX)
        stall_count <= stall_count + CNT_W'(1);
      if (flush_inc && flush_count != CNT_MAX)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  assign state           = state_q;
  assign hz.pc_write     = ctl.pc_write;
  assign hz.if_id_write  = ctl.if_id_write;
  assign hz.if_id_flush  = ctl.if_id_flush;
  assign hz.id_ex_write  = ctl.id_ex_write;
  assign hz.id_ex_bubble = ctl.id_ex_bubble;
  assign hz.ex_mem_write = ctl.ex_mem_write;
  assign hz.ex_mem_flush = ctl.ex_mem_flush;
  assign hz.mem_wb_write = ctl.mem_wb_write;
endmodule
